gpio_packet_rx: RTL
===================

GPIO_PACKET_RX -- requirements
Module: gpio_packet_rx

Interface
REQ-001 SHALL have parameter PKT_W, default 112, packet payload width in bits.
REQ-002 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port gpio_bit  input  1  serial data bit from GPIO pad.
REQ-005 SHALL have port gpio_bit_vld  input  1  qualifies gpio_bit for one clk cycle (one bit per asserted cycle).
REQ-006 SHALL have port pkt_ready  input  1  downstream accepts packet this cycle.
REQ-007 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-008 SHALL have port pkt_data  output  PKT_W  assembled packet; first received bit in pkt_data[PKT_W-1].
REQ-009 SHALL have port pkt_valid  output  1  pkt_data holds a complete, parity-clean packet.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port parity_err  output  1  sticky; a packet failed even-parity check.
REQ-012 SHALL have port overrun_err  output  1  sticky; a qualified bit arrived while in HOLD.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, PARITY, HOLD.
REQ-014 IDLE: qualified bit of value 1 (start bit) SHALL move to SHIFT with bit counter = 0; qualified 0 bits SHALL be ignored.
REQ-015 SHIFT: each qualified bit SHALL be shifted into the LSB of the shift register (left shift) and increment the counter; the qualified bit that makes the count equal PKT_W SHALL move to PARITY.
REQ-016 Bit counter SHALL be $clog2(PKT_W+1) bits wide and SHALL never wrap past PKT_W.
REQ-017 Cycles with gpio_bit_vld low SHALL hold state, counter and shift register unchanged (no timeout).
REQ-018 PARITY: the qualified bit SHALL be XORed with the XOR of all PKT_W payload bits; result 0 SHALL move to HOLD, result 1 SHALL set parity_err and return to IDLE, discarding the packet.
REQ-019 HOLD: pkt_valid SHALL be 1 and pkt_data stable; pkt_data SHALL change only on the shift-register write path while not in HOLD.
REQ-020 HOLD with pkt_ready=1 SHALL return to IDLE next cycle; pkt_valid SHALL be registered and drop in that cycle.
REQ-021 Handshake latency: pkt_valid SHALL rise on the cycle after the parity bit is sampled; minimum start-bit-to-pkt_valid latency is PKT_W+2 qualified bits plus 1 cycle.
REQ-022 A start bit arriving in the same cycle as a pkt_ready handshake in HOLD SHALL be ignored and SHALL set overrun_err.
REQ-023 HOLD with gpio_bit_vld=1 SHALL set overrun_err and drop the bit; the held packet SHALL be unaffected.
REQ-024 err_clr SHALL clear both sticky flags next cycle; a simultaneous set condition SHALL win over err_clr.
REQ-025 pkt_ready outside HOLD SHALL have no effect.
REQ-026 PKT_W=1 SHALL be supported with identical state sequence.

Reset
REQ-027 Reset SHALL force IDLE, counter 0, pkt_data 0, pkt_valid 0, busy 0, parity_err 0, overrun_err 0.
REQ-028 Reset SHALL take priority over all inputs, including mid-SHIFT and during HOLD; a partial or held packet SHALL be lost.

Verification
REQ-029 PKT_W=112, start bit, payload 0xA5 repeated 14 times MSB first, parity 0 -> pkt_valid=1 and pkt_data=0xA5..A5 one cycle after parity bit; pkt_ready=1 -> pkt_valid=0 next cycle, busy=0.
REQ-030 Same payload with parity bit 1 -> pkt_valid never asserts, parity_err=1, state IDLE; err_clr pulse -> parity_err=0.
REQ-031 Bits with gpio_bit_vld toggling every third cycle, payload 112'h1 -> pkt_data=112'h1, parity bit 1 accepted, latency scales with gaps only.
REQ-032 Packet held, pkt_ready=0 for 10 cycles while gpio_bit_vld=1 with bit 1 -> overrun_err=1, pkt_data unchanged, no new packet starts after pkt_ready.
REQ-033 Reset asserted after 50 payload bits, then a full clean packet 112'hFFFF...F with parity 0 -> pkt_data all ones, no residue of aborted bits.
REQ-034 Leading qualified 0 bits (20 of them) in IDLE before start -> ignored; busy stays 0 until start bit.

Source files
------------

// File: rtl/gpio_packet_rx.sv
// gpio_packet_rx
//   Serial packet receiver for a GPIO-sampled bit stream. A qualified '1'
//   in IDLE is the start bit; the next PKT_W qualified bits form the
//   payload (first bit ends up in the MSB). One more qualified bit is an
//   even-parity bit. A clean packet is presented on pkt_data/pkt_valid
//   until pkt_ready; a bad packet is dropped and flagged.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   gpio_bit     serial data bit
//   gpio_bit_vld qualifies gpio_bit for one cycle
//   pkt_ready    downstream accepts the held packet
//   err_clr      clears the sticky error flags
//   pkt_data     assembled packet (PKT_W bits)
//   pkt_valid    pkt_data holds a complete, parity-clean packet
//   busy         receiver is not idle
//   parity_err   sticky: a packet failed the even-parity check
//   overrun_err  sticky: a qualified bit arrived while a packet was held
module gpio_packet_rx #(
   parameter int PKT_W = 112
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             gpio_bit,
   input  logic             gpio_bit_vld,
   input  logic             pkt_ready,
   input  logic             err_clr,
   output logic [PKT_W-1:0] pkt_data,
   output logic             pkt_valid,
   output logic             busy,
   output logic             parity_err,
   output logic             overrun_err
);

   localparam int CW = $clog2(PKT_W + 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SHIFT  = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] HOLD   = 2'd3;

   localparam logic [CW-1:0] LAST = CW'(PKT_W - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          parity_bad;
   logic          set_perr;
   logic          set_oerr;

   // pkt_data doubles as the shift register, so its XOR is the payload parity.
   assign parity_bad = (^pkt_data) ^ gpio_bit;
   assign busy       = (state != IDLE);

   always_comb begin
      set_perr = 1'b0;
      set_oerr = 1'b0;
      if (gpio_bit_vld) begin
         set_perr = (state == PARITY) && parity_bad;
         set_oerr = (state == HOLD);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pkt_data  <= '0;
         pkt_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gpio_bit_vld && gpio_bit) begin
                  state <= SHIFT;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               if (gpio_bit_vld) begin
                  // Shift expressed without a part-select so PKT_W=1 elaborates.
                  pkt_data <= (pkt_data << 1) | PKT_W'(gpio_bit);
                  cnt      <= cnt + CW'(1);
                  if (cnt == LAST)
                     state <= PARITY;
               end
            end
            PARITY: begin
               if (gpio_bit_vld) begin
                  if (parity_bad) begin
                     state <= IDLE;
                  end else begin
                     state     <= HOLD;
                     pkt_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               // Bits arriving here are dropped (flagged via set_oerr),
               // including a start bit coincident with the handshake.
               if (pkt_ready) begin
                  state     <= IDLE;
                  pkt_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               pkt_valid <= 1'b0;
            end
         endcase
      end
   end

   // Sticky flags: a set condition in the same cycle wins over err_clr.
   always_ff @(posedge clk) begin
      if (reset) begin
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         parity_err  <= set_perr | (parity_err  & ~err_clr);
         overrun_err <= set_oerr | (overrun_err & ~err_clr);
      end
   end

endmodule
